// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexed fully-connected ReLU layer on one shared MAC datapath.
// Streams one neuron result at a time and reads weights/biases from external sync memories.
module neuron_layer_sequencer #(
  parameter int INPUT_COUNT  = 4,
  parameter int NEURON_COUNT = 4,
  parameter int WA_W = (INPUT_COUNT * NEURON_COUNT > 1) ? $clog2(INPUT_COUNT * NEURON_COUNT) : 1,
  parameter int BA_W = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [32*INPUT_COUNT-1:0] x,
  output logic                     w_en,
  output logic [WA_W-1:0]          w_addr,
  input  logic [31:0]              w_data,
  output logic [BA_W-1:0]          b_addr,
  input  logic [31:0]              b_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BA_W-1:0]          out_idx,
  output logic [31:0]              out_data,
  output logic                     busy,
  output logic                     done
);

  localparam int IC_W = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
  localparam int XW   = 32 * INPUT_COUNT;
  localparam logic [IC_W-1:0] I_LAST = IC_W'(INPUT_COUNT - 1);
  localparam logic [IC_W-1:0] I_PEN  = IC_W'((INPUT_COUNT >= 2) ? INPUT_COUNT - 2 : 0);
  localparam logic [IC_W-1:0] I_ONE  = IC_W'(1);
  localparam logic [BA_W-1:0] N_LAST = BA_W'(NEURON_COUNT - 1);
  localparam logic [BA_W-1:0] N_ONE  = BA_W'(1);
  localparam logic [WA_W-1:0] WA_ONE = WA_W'(1);

  typedef enum logic [1:0] {IDLE, FETCH, MAC, OUT} stateType;

  stateType          state;
  logic [XW-1:0]     xReg;
  logic [31:0]       acc;
  logic [BA_W-1:0]   n;
  logic [IC_W-1:0]   i;

  logic [XW-1:0]     xRot;
  logic [31:0]       prod;
  logic [31:0]       accNext;

  // The latched vector rotates one word per MAC cycle, so the current x[i]
  // always sits in the low word; after INPUT_COUNT rotations it is back in place.
  always_comb begin
    xRot    = (xReg >> 32) | (xReg << (XW - 32));
    prod    = xReg[31:0] * w_data;
    accNext = ((i == '0) ? b_data : acc) + prod;
  end

  // w_addr simply counts up through each neuron's weight row; after the last
  // MAC cycle it already points at the next neuron's first weight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      xReg      <= '0;
      acc       <= '0;
      n         <= '0;
      i         <= '0;
      w_en      <= 1'b0;
      w_addr    <= '0;
      b_addr    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xReg   <= x;
            n      <= '0;
            w_en   <= 1'b1;
            w_addr <= '0;
            b_addr <= '0;
            busy   <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          i      <= '0;
          w_en   <= (INPUT_COUNT > 1);
          w_addr <= w_addr + WA_ONE;
          state  <= MAC;
        end
        MAC: begin
          acc  <= accNext;
          xReg <= xRot;
          if (i == I_LAST) begin
            w_en      <= 1'b0;
            out_valid <= 1'b1;
            out_idx   <= n;
            out_data  <= accNext[31] ? 32'd0 : accNext;
            state     <= OUT;
          end else begin
            i      <= i + I_ONE;
            w_en   <= (i != I_PEN);
            w_addr <= w_addr + WA_ONE;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (n == N_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              n      <= n + N_ONE;
              b_addr <= n + N_ONE;
              w_en   <= 1'b1;
              state  <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Bench for neuron_layer_sequencer: sync-read memory model, backpressure driver,
// and a reference model computing each neuron's ReLU(b + sum x*w) directly.
module tb_neuron_layer_sequencer;

  localparam int IC = 4;
  localparam int NC = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [32*IC-1:0]  x = '0;
  logic              w_en;
  logic [3:0]        w_addr;
  logic [31:0]       w_data = '0;
  logic [1:0]        b_addr;
  logic [31:0]       b_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [1:0]        out_idx;
  logic [31:0]       out_data;
  logic              busy;
  logic              done;

  neuron_layer_sequencer #(.INPUT_COUNT(IC), .NEURON_COUNT(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] wMem [IC*NC];
  logic [31:0] bMem [NC];
  logic [31:0] xStim [IC];

  // External synchronous-read weight/bias memory
  always @(posedge clk) begin
    if (w_en) begin
      w_data <= wMem[w_addr];
      b_data <= bMem[b_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int base = 0;
  int doneCount = 0;
  int doneRel = -1;
  int fixedStall = 0;
  bit randStall = 0;

  logic [31:0] obsIdx[$];
  logic [31:0] obsData[$];
  int          obsRel[$];
  int          stallQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelNeuron(input int nn);
    logic [31:0] sum;
    sum = bMem[nn];
    for (int k = 0; k < IC; k++) sum = sum + xStim[k] * wMem[nn*IC + k];
    return ($signed(sum) < 0) ? 32'd0 : sum;
  endfunction

  // Downstream side: chooses a stall length for each new result, checks that
  // a stalled result is held, and records every handshake with its cycle.
  int   stallCnt = 0;
  int   curTarget = 0;
  bit   armed = 0;
  bit   prevStall = 0;
  logic [31:0] heldData;
  logic [1:0]  heldIdx;
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 0;
      stallCnt  = 0;
      armed     = 0;
      out_ready = 1'b0;
    end else begin
      if (done) begin
        doneCount++;
        doneRel = cyc - base + 1;
        checkOutput("doneBusy", 32'(busy), 32'd0);
      end
      if (prevStall) begin
        checkOutput("holdValid", 32'(out_valid), 32'd1);
        checkOutput("holdData", out_data, heldData);
        checkOutput("holdIdx", 32'(out_idx), 32'(heldIdx));
        checkOutput("wEnStall", 32'(w_en), 32'd0);
      end
      if (!out_valid) begin
        armed     = 0;
        stallCnt  = 0;
        out_ready = 1'b0;
      end else begin
        if (!armed) begin
          armed     = 1;
          curTarget = randStall ? int'($urandom_range(0, 3)) : fixedStall;
          stallQ.push_back(curTarget);
        end
        if (stallCnt < curTarget) begin
          stallCnt++;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
        end
      end
      prevStall = out_valid && !out_ready;
      heldData  = out_data;
      heldIdx   = out_idx;
      if (out_valid && out_ready) begin
        obsIdx.push_back(32'(out_idx));
        obsData.push_back(out_data);
        obsRel.push_back(cyc - base + 1);
      end
    end
  end

  task automatic loadX();
    for (int k = 0; k < IC; k++) x[32*k +: 32] = xStim[k];
  endtask

  task automatic clearObs(input int stall, input bit rnd);
    obsIdx.delete(); obsData.delete(); obsRel.delete(); stallQ.delete();
    doneCount  = 0;
    doneRel    = -1;
    fixedStall = stall;
    randStall  = rnd;
  endtask

  // Pulse start for the accepting edge; base marks that edge as cycle 0
  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    base  = cyc;
    start = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_wen"}, 32'(w_en), 32'd0);
    checkOutput({tag, "_data"}, out_data, 32'd0);
    checkOutput({tag, "_idx"}, 32'(out_idx), 32'd0);
    checkOutput({tag, "_waddr"}, 32'(w_addr), 32'd0);
    checkOutput({tag, "_baddr"}, 32'(b_addr), 32'd0);
  endtask

  task automatic runPass(input string name, input int stall, input bit rnd,
                         input bit midStart, input bit zeroX);
    int expRel;
    int waited;
    int rel;
    clearObs(stall, rnd);
    loadX();
    applyStimulus();
    waited = 0;
    while (doneCount == 0 && waited < 400) begin
      @(negedge clk);
      waited++;
      rel = cyc - base + 1;
      if (midStart) start = (rel == 3 || rel == 6);
      if (zeroX && rel == 2) x = '0;
    end
    start = 1'b0;
    if (doneCount == 0) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput({name, "_count"}, 32'(obsData.size()), 32'(NC));
    expRel = 0;
    for (int k = 0; k < NC; k++) begin
      if (k < obsData.size() && k < stallQ.size()) begin
        expRel += IC + 2 + stallQ[k];
        checkOutput($sformatf("%s_idx%0d", name, k), obsIdx[k], 32'(k));
        checkOutput($sformatf("%s_data%0d", name, k), obsData[k], modelNeuron(k));
        checkOutput($sformatf("%s_time%0d", name, k), obsRel[k], expRel);
      end
    end
    checkOutput({name, "_doneTime"}, doneRel, expRel + 1);
    checkOutput({name, "_doneOnce"}, doneCount, 32'd1);
    checkOutput({name, "_idleAfter"}, 32'(busy), 32'd0);
  endtask

  task automatic setBasic();
    for (int k = 0; k < IC; k++) xStim[k] = 32'(k + 1);
    for (int k = 0; k < IC; k++) begin
      wMem[0*IC + k] = 32'd1;
      wMem[1*IC + k] = 32'hFFFF_FFFF;
      wMem[2*IC + k] = 32'd0;
      wMem[3*IC + k] = (k == IC - 1) ? 32'd1 : 32'd0;
    end
    bMem[0] = 32'd0; bMem[1] = 32'd5; bMem[2] = 32'd0; bMem[3] = 32'd7;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    int dCyc;
    setBasic();
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    $display("[TB] basic pass");
    runPass("basic", 0, 0, 0, 0);
    if (obsData.size() == NC) begin
      checkOutput("basicN0", obsData[0], 32'd10);
      checkOutput("basicN3", obsData[3], 32'd11);
    end

    $display("[TB] backpressure pass");
    runPass("stall3", 3, 0, 0, 0);

    $display("[TB] wrap and sign");
    xStim[0] = 32'h4000_0000; xStim[1] = 32'd1; xStim[2] = 32'd0; xStim[3] = 32'd0;
    for (int k = 0; k < IC*NC; k++) wMem[k] = $urandom;
    wMem[0] = 32'd4; wMem[1] = 32'd0; wMem[2] = 32'd0; wMem[3] = 32'd0;
    wMem[4] = 32'd0; wMem[5] = 32'd1; wMem[6] = 32'd0; wMem[7] = 32'd0;
    bMem[0] = 32'd1; bMem[1] = 32'h7FFF_FFFF; bMem[2] = $urandom; bMem[3] = $urandom;
    runPass("wrap", 0, 0, 0, 0);
    if (obsData.size() >= 2) begin
      checkOutput("wrapPos", obsData[0], 32'd1);
      checkOutput("wrapNeg", obsData[1], 32'd0);
    end

    $display("[TB] start while busy and x change after accept");
    setBasic();
    runPass("midStart", 0, 0, 1, 0);
    runPass("xChange", 0, 0, 0, 1);

    $display("[TB] start held through done");
    clearObs(0, 0);
    loadX();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    dCyc = -1;
    waited = 0;
    while (dCyc < 0 && waited < 200) begin
      @(negedge clk);
      waited++;
      if (done) dCyc = cyc - base + 1;
    end
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (doneCount < 2 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("b2bFirstDone", dCyc, 32'd25);
    checkOutput("b2bCount", 32'(obsData.size()), 32'(2*NC));
    for (int k = 0; k < NC; k++) begin
      if (obsData.size() == 2*NC) begin
        checkOutput($sformatf("b2bData%0d", k), obsData[NC + k], modelNeuron(k));
        checkOutput($sformatf("b2bTime%0d", k), obsRel[NC + k], dCyc + (k + 1) * (IC + 2));
      end
    end
    checkOutput("b2bDoneTime", doneRel, dCyc + NC * (IC + 2) + 1);

    $display("[TB] reset mid-pass");
    clearObs(0, 0);
    loadX();
    applyStimulus();
    waited = 0;
    while (cyc - base + 1 < 9 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetState("midReset");
    repeat (6) @(negedge clk);
    checkOutput("midResetNoDone", doneCount, 32'd0);
    checkOutput("midResetIdle", 32'(busy), 32'd0);
    runPass("afterReset", 0, 0, 0, 0);

    $display("[TB] random passes");
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < IC; k++) xStim[k] = $urandom;
      for (int k = 0; k < IC*NC; k++) wMem[k] = $urandom;
      for (int k = 0; k < NC; k++) bMem[k] = $urandom;
      runPass($sformatf("rand%0d", p), 0, 1, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
